// File: rtl/textmem_arbiter.sv
// Two-master Wishbone-classic arbiter for the text-buffer memory: display fetch has priority,
// CPU gets a forced slot after MAXHOLD contended display grants, and a timeout ends hung transfers.
module textmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXHOLD = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            v_cyc_i,
  input  logic [AW-1:0]   v_adr_i,
  output logic [DW-1:0]   v_dat_o,
  output logic            v_ack_o,
  input  logic            c_cyc_i,
  input  logic            c_stb_i,
  input  logic            c_we_i,
  input  logic [DW/8-1:0] c_sel_i,
  input  logic [AW-1:0]   c_adr_i,
  input  logic [DW-1:0]   c_dat_i,
  output logic [DW-1:0]   c_dat_o,
  output logic            c_ack_o,
  output logic            c_err_o,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_sel_o,
  output logic [AW-1:0]   m_adr_o,
  output logic [DW-1:0]   m_dat_o,
  input  logic [DW-1:0]   m_dat_i,
  input  logic            m_ack_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, VID = 2'b01, CPU = 2'b10} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAXHOLD);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] hold, hold_nxt;
  logic [9:0] tcnt;
  logic       vreq, creq, own_req, tmo;

  assign vreq = v_cyc_i;
  assign creq = c_cyc_i & c_stb_i;
  assign tmo  = (tcnt == TMO_LAST);

  always_comb begin
    own_req = 1'b0;
    case (state)
      VID:     own_req = v_cyc_i;
      CPU:     own_req = c_cyc_i;
      default: own_req = 1'b0;
    endcase
  end

  // State and counters; the timeout counter sits at zero in IDLE so every grant starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      hold  <= 8'd0;
      tcnt  <= 10'd0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      if (state == IDLE || state_nxt == IDLE)
        tcnt <= 10'd0;
      else
        tcnt <= tcnt + 10'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (vreq && creq) begin
          if (hold < HOLD_MAX) begin
            state_nxt = VID;
            hold_nxt  = hold + 8'd1;
          end else begin
            state_nxt = CPU;
            hold_nxt  = 8'd0;
          end
        end else if (vreq) begin
          state_nxt = VID;
          hold_nxt  = 8'd0;
        end else if (creq) begin
          state_nxt = CPU;
          hold_nxt  = 8'd0;
        end
      end
      VID, CPU: begin
        if (!own_req || m_ack_i || tmo)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An owner that drops its cycle gets nothing forwarded, even if the memory acks in that cycle.
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = '0;
    m_adr_o = '0;
    m_dat_o = '0;
    v_ack_o = 1'b0;
    v_dat_o = '0;
    c_ack_o = 1'b0;
    c_err_o = 1'b0;
    c_dat_o = '0;
    case (state)
      VID: begin
        if (v_cyc_i) begin
          m_cyc_o = 1'b1;
          m_stb_o = 1'b1;
          m_sel_o = '1;
          m_adr_o = v_adr_i;
          v_ack_o = m_ack_i | tmo;
          v_dat_o = (tmo && !m_ack_i) ? '0 : m_dat_i;
        end
      end
      CPU: begin
        if (c_cyc_i) begin
          m_cyc_o = 1'b1;
          m_stb_o = c_stb_i;
          m_we_o  = c_we_i;
          m_sel_o = c_sel_i;
          m_adr_o = c_adr_i;
          m_dat_o = c_dat_i;
          c_ack_o = m_ack_i;
          c_err_o = tmo & ~m_ack_i;
          c_dat_o = m_dat_i;
        end
      end
      default: ;
    endcase
  end

  assign grant_o = state;

endmodule

// File: tb/tb_textmem_arbiter.sv
// Self-checking bench for textmem_arbiter: scoreboard of expected completions plus directed checks.
module tb_textmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            v_cyc_i;
  logic [AW-1:0]   v_adr_i;
  logic [DW-1:0]   v_dat_o;
  logic            v_ack_o;
  logic            c_cyc_i, c_stb_i, c_we_i;
  logic [DW/8-1:0] c_sel_i;
  logic [AW-1:0]   c_adr_i;
  logic [DW-1:0]   c_dat_i;
  logic [DW-1:0]   c_dat_o;
  logic            c_ack_o, c_err_o;
  logic            m_cyc_o, m_stb_o, m_we_o;
  logic [DW/8-1:0] m_sel_o;
  logic [AW-1:0]   m_adr_o;
  logic [DW-1:0]   m_dat_o;
  logic [DW-1:0]   m_dat_i;
  logic            m_ack_i;
  logic [1:0]      grant_o;

  textmem_arbiter #(.AW(AW), .DW(DW), .MAXHOLD(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .v_cyc_i(v_cyc_i), .v_adr_i(v_adr_i), .v_dat_o(v_dat_o), .v_ack_o(v_ack_o),
    .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i), .c_sel_i(c_sel_i),
    .c_adr_i(c_adr_i), .c_dat_i(c_dat_i), .c_dat_o(c_dat_o), .c_ack_o(c_ack_o), .c_err_o(c_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  kind;   // 1 display ack, 2 CPU ack, 3 CPU error
    logic [31:0] dat;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] trace[$];
  bit         trace_en = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  exp_t       mon_e;
  logic [1:0] mon_k;
  int         n_chk = 0;
  int         n_err = 0;

  // Memory model: acks on granted cycle mem_lat (0 = never); spur_ack forces an ack anytime.
  int          mem_lat = 1;
  int          gcnt;
  logic        spur_ack = 1'b0;
  logic [31:0] rd_dat = 32'd0;

  assign m_ack_i = spur_ack | ((mem_lat != 0) && m_cyc_o && m_stb_o && (gcnt == mem_lat - 1));
  assign m_dat_i = rd_dat;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) gcnt <= 0;
    else       gcnt <= m_cyc_o ? gcnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero();
    chk("zero_m_ctl", 64'({grant_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}), 64'd0);
    chk("zero_m_adr", 64'(m_adr_o), 64'd0);
    chk("zero_m_dat", 64'(m_dat_o), 64'd0);
    chk("zero_acks",  64'({v_ack_o, c_ack_o, c_err_o}), 64'd0);
    chk("zero_v_dat", 64'(v_dat_o), 64'd0);
    chk("zero_c_dat", 64'(c_dat_o), 64'd0);
  endtask

  // Non-owner quiet checks and scoreboard pop on every completion.
  always @(negedge clk_i) begin
    if (grant_o != 2'b01) chk("v_quiet", 64'({v_ack_o, v_dat_o}), 64'd0);
    if (grant_o != 2'b10) chk("c_quiet", 64'({c_ack_o, c_err_o, c_dat_o}), 64'd0);
    if (grant_o == 2'b00) chk("m_idle", 64'(m_cyc_o), 64'd0);
    if (v_ack_o || c_ack_o || c_err_o) begin
      mon_k = v_ack_o ? 2'd1 : (c_ack_o ? 2'd2 : 2'd3);
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 64'(mon_k), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_kind", 64'(mon_k), 64'(mon_e.kind));
        if (mon_k == 2'd1)      chk("sb_v_dat", 64'(v_dat_o), 64'(mon_e.dat));
        else if (mon_k == 2'd2) chk("sb_c_dat", 64'(c_dat_o), 64'(mon_e.dat));
      end
    end
    if (trace_en && grant_o != 2'b00 && prev_grant == 2'b00) trace.push_back(grant_o);
    prev_grant = grant_o;
  end

  // Called at posedge+1 in IDLE; returns granted cycles and negedges waited before the grant.
  task automatic vid_xfer(input logic [31:0] adr, input logic [31:0] dat, input int lat,
                          input bit tmo_exp, output int ncyc, output int nwait);
    exp_t e;
    bit   done;
    mem_lat = lat;
    rd_dat  = dat;
    v_adr_i = adr;
    v_cyc_i = 1'b1;
    e.kind  = 2'd1;
    e.dat   = tmo_exp ? 32'd0 : dat;
    sbq.push_back(e);
    ncyc = 0; nwait = 0; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (m_cyc_o) begin
        ncyc++;
        if (ncyc == 1)
          chk("vid_ctl", 64'({m_we_o, m_stb_o, m_sel_o, m_adr_o}), 64'({1'b0, 1'b1, 4'hF, adr}));
      end else if (ncyc == 0) begin
        nwait++;
      end
      if (v_ack_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("vid_done", 64'(done), 64'd1);
    tick();
    v_cyc_i = 1'b0;
    @(negedge clk_i);
    chk("vid_idle_after", 64'(grant_o), 64'd0);
    tick();
  endtask

  task automatic cpu_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [31:0] rdat, input int lat,
                          input bit tmo_exp, output int ncyc, output int nwait);
    exp_t e;
    bit   done;
    mem_lat = lat;
    rd_dat  = rdat;
    c_we_i  = we; c_sel_i = sel; c_adr_i = adr; c_dat_i = wdat;
    c_cyc_i = 1'b1; c_stb_i = 1'b1;
    e.kind  = tmo_exp ? 2'd3 : 2'd2;
    e.dat   = rdat;
    sbq.push_back(e);
    ncyc = 0; nwait = 0; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (m_cyc_o) begin
        ncyc++;
        if (ncyc == 1) begin
          chk("cpu_ctl", 64'({m_we_o, m_stb_o, m_sel_o, m_adr_o}), 64'({we, 1'b1, sel, adr}));
          chk("cpu_wdat", 64'(m_dat_o), 64'(wdat));
        end
      end else if (ncyc == 0) begin
        nwait++;
      end
      if (c_ack_o || c_err_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("cpu_done", 64'(done), 64'd1);
    tick();
    c_cyc_i = 1'b0; c_stb_i = 1'b0;
    @(negedge clk_i);
    chk("cpu_idle_after", 64'(grant_o), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   nc, nw, nack;
    exp_t e;
    rst_i = 1'b1;
    v_cyc_i = 1'b0; v_adr_i = '0;
    c_cyc_i = 1'b0; c_stb_i = 1'b0; c_we_i = 1'b0; c_sel_i = '0; c_adr_i = '0; c_dat_i = '0;
    repeat (2) @(negedge clk_i);
    check_all_zero();
    tick();
    rst_i = 1'b0;
    tick();

    // Display-only read, ack on second granted cycle
    vid_xfer(32'h40, 32'h41424344, 2, 1'b0, nc, nw);
    chk("vid_cycles", 64'(nc), 64'd2);
    chk("vid_latency", 64'(nw), 64'd1);

    // CPU write and CPU read
    cpu_xfer(1'b1, 4'h3, 32'h10, 32'hDEADBEEF, 32'h0BAD0BAD, 2, 1'b0, nc, nw);
    chk("cpu_wr_cycles", 64'(nc), 64'd2);
    chk("cpu_wr_latency", 64'(nw), 64'd1);
    cpu_xfer(1'b0, 4'hF, 32'h20, 32'h0, 32'h12345678, 1, 1'b0, nc, nw);
    chk("cpu_rd_cycles", 64'(nc), 64'd1);

    // Contention: 8 display grants then one CPU grant, twice
    mem_lat = 1;
    rd_dat  = 32'hC0FFEE00;
    for (int i = 0; i < 18; i++) begin
      e.kind = (i % 9 == 8) ? 2'd2 : 2'd1;
      e.dat  = 32'hC0FFEE00;
      sbq.push_back(e);
    end
    trace.delete();
    trace_en = 1'b1;
    v_adr_i = 32'h80; v_cyc_i = 1'b1;
    c_we_i = 1'b0; c_sel_i = 4'hF; c_adr_i = 32'h84; c_cyc_i = 1'b1; c_stb_i = 1'b1;
    nack = 0;
    for (int i = 0; i < 200 && nack < 18; i++) begin
      @(negedge clk_i);
      if (v_ack_o || c_ack_o) nack++;
    end
    chk("cont_acks", 64'(nack), 64'd18);
    tick();
    v_cyc_i = 1'b0; c_cyc_i = 1'b0; c_stb_i = 1'b0;
    trace_en = 1'b0;
    chk("cont_trace_len", 64'(trace.size()), 64'd18);
    for (int i = 0; i < 18 && i < trace.size(); i++)
      chk("cont_grant", 64'(trace[i]), (i % 9 == 8) ? 64'd2 : 64'd1);
    tick();

    // Timeouts: CPU error and display forced ack at granted cycle 16
    cpu_xfer(1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0, 0, 1'b1, nc, nw);
    chk("cpu_tmo_cycles", 64'(nc), 64'd16);
    vid_xfer(32'h44, 32'h55555555, 0, 1'b1, nc, nw);
    chk("vid_tmo_cycles", 64'(nc), 64'd16);
    // Ack in the timeout cycle is a normal ack
    vid_xfer(32'h48, 32'h99887766, 16, 1'b0, nc, nw);
    chk("vid_ack_last_cycles", 64'(nc), 64'd16);

    // Display abort with a coincident ack, then a stray ack in IDLE
    mem_lat = 0;
    v_adr_i = 32'h50; v_cyc_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("abort_granted", 64'({grant_o, m_cyc_o}), 64'({2'b01, 1'b1}));
    tick();
    v_cyc_i = 1'b0;
    spur_ack = 1'b1;
    @(negedge clk_i);
    chk("abort_mcyc", 64'(m_cyc_o), 64'd0);
    chk("abort_vack", 64'(v_ack_o), 64'd0);
    chk("abort_grant", 64'(grant_o), 64'd1);
    tick();
    @(negedge clk_i);
    chk("abort_idle", 64'(grant_o), 64'd0);
    chk("stray_ack_acks", 64'({v_ack_o, c_ack_o, c_err_o}), 64'd0);
    tick();
    spur_ack = 1'b0;
    @(negedge clk_i);
    chk("stray_ack_grant", 64'(grant_o), 64'd0);
    tick();

    // Asynchronous reset in the middle of a CPU grant
    mem_lat = 0;
    c_we_i = 1'b1; c_sel_i = 4'hF; c_adr_i = 32'h60; c_dat_i = 32'h600DF00D;
    c_cyc_i = 1'b1; c_stb_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_pre_grant", 64'({grant_o, m_cyc_o}), 64'({2'b10, 1'b1}));
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero();
    c_cyc_i = 1'b0; c_stb_i = 1'b0; c_we_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    vid_xfer(32'h70, 32'hA1B2C3D4, 1, 1'b0, nc, nw);
    chk("post_rst_latency", 64'(nw), 64'd1);
    chk("post_rst_cycles", 64'(nc), 64'd1);

    repeat (2) @(negedge clk_i);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
